xif_dma_master: RTL and testbench

- Bus initiator for the MemSplit32-style split request/response bus (req/we/addr/be/wdata → ack; resp/rdata returned later).
- Copies a block of 32-bit words from a source address range to a destination range, one read then one write per word.
- Sits on the initiator side of the tile's external bus, opposite the CSR/accelerator responders.
- Driven by a start/length command interface; reports busy, done and error.

---
 rtl/xif_dma_master_if.sv | 15 +
 rtl/xif_dma_master.sv | 149 ++++++++++++++
 tb/tb_xif_dma_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xif_dma_master_if.sv
// Split request/response bus between the copy engine and its responder.
// The master drives requests; read data comes back later on resp/rdata.
interface xif_dma_master_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;

    modport master (output req, we, addr, be, wdata, input ack, resp, rdata);
    modport slave  (input req, we, addr, be, wdata, output ack, resp, rdata);
endinterface

// File: rtl/xif_dma_master.sv
// Word-by-word block copy engine: one read, then one write, per 32-bit word.
// Status and bus outputs are all registered; a read resp timeout aborts the copy.
module xif_dma_master #(
    parameter int LEN_W        = 16,
    parameter int RESP_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 start_i,
    input  logic [31:0]          src_addr_bi,
    input  logic [31:0]          dst_addr_bi,
    input  logic [LEN_W-1:0]     len_bi,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    xif_dma_master_if.master     bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_FIN     = 3'd4;

    localparam int TMO_W = (RESP_TIMEOUT > 2) ? $clog2(RESP_TIMEOUT) : 1;
    // Abort on the cycle in which the counter would step onto RESP_TIMEOUT-1.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 2);

    logic [2:0]       r_state;
    logic [29:0]      r_src;
    logic [29:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [TMO_W-1:0] r_tmo;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             w_unused;

    assign w_unused  = ^{src_addr_bi[1:0], dst_addr_bi[1:0]};

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign bus.req   = r_req;
    assign bus.we    = r_we;
    assign bus.addr  = r_addr;
    assign bus.be    = 4'hF;
    assign bus.wdata = r_wdata;

    // Copy sequencer; bus and status outputs are loaded with their next-cycle values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_src   <= 30'd0;
            r_dst   <= 30'd0;
            r_len   <= '0;
            r_tmo   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= start_i;
                    if (start_i) begin
                        r_src <= src_addr_bi[31:2];
                        r_dst <= dst_addr_bi[31:2];
                        r_len <= len_bi;
                        if (len_bi == '0) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_RD_REQ;
                            r_req   <= 1'b1;
                            r_we    <= 1'b0;
                            r_addr  <= {src_addr_bi[31:2], 2'b00};
                        end
                    end
                end
                S_RD_REQ: begin
                    if (bus.ack) begin
                        r_tmo <= '0;
                        // A resp landing in the ack cycle skips the wait state.
                        if (bus.resp) begin
                            r_state <= S_WR_REQ;
                            r_we    <= 1'b1;
                            r_addr  <= {r_dst, 2'b00};
                            r_wdata <= bus.rdata;
                        end else begin
                            r_state <= S_RD_WAIT;
                            r_req   <= 1'b0;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (bus.resp) begin
                        r_state <= S_WR_REQ;
                        r_req   <= 1'b1;
                        r_we    <= 1'b1;
                        r_addr  <= {r_dst, 2'b00};
                        r_wdata <= bus.rdata;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_WR_REQ: begin
                    if (bus.ack) begin
                        r_src <= r_src + 30'd1;
                        r_dst <= r_dst + 30'd1;
                        r_len <= r_len - LEN_W'(1);
                        if (r_len == LEN_W'(1)) begin
                            r_state <= S_FIN;
                            r_req   <= 1'b0;
                            r_we    <= 1'b0;
                        end else begin
                            r_state <= S_RD_REQ;
                            r_we    <= 1'b0;
                            r_addr  <= {r_src + 30'd1, 2'b00};
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xif_dma_master.sv
// Randomized copy bench: a memory responder with programmable latency logs bus
// traffic, which is compared against a transaction list built from the copy rules.
module tb_xif_dma_master;

    localparam int LEN_W = 16;
    localparam int TMO   = 16;
    localparam int LIMIT = 3000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             start;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;

    xif_dma_master_if bus();

    xif_dma_master #(.LEN_W(LEN_W), .RESP_TIMEOUT(TMO)) u_dut (
        .clk_i       (clk),
        .arst_n_i    (arst_n),
        .start_i     (start),
        .src_addr_bi (src),
        .dst_addr_bi (dst),
        .len_bi      (len),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    longint      cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    longint      err_cyc = 0;
    longint      ack_cyc = 0;
    int          unstable = 0;
    int          be_bad = 0;
    int          ack_dly = 0;
    int          resp_dly = 1;
    bit          no_resp = 1'b0;
    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] mem[logic [31:0]];
    logic [31:0] exp_mem[logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h1111_1111;
            32'h0000_0104: return 32'h2222_2222;
            32'h0000_0108: return 32'h3333_3333;
            default:       return a ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    // Memory responder: acks after ack_dly waiting cycles, returns read data resp_dly cycles later.
    initial begin
        int          aw = 0;
        int          rc = 0;
        logic [31:0] ra = 32'd0;
        logic [31:0] s_addr = 32'd0;
        logic [31:0] s_wd = 32'd0;
        logic        s_we = 1'b0;
        txn_t        t;
        bus.ack = 1'b0; bus.resp = 1'b0; bus.rdata = 32'd0;
        forever begin
            @(negedge clk);
            bus.ack  = 1'b0;
            bus.resp = 1'b0;
            if (!arst_n) begin
                aw = 0; rc = 0;
            end else begin
                if (rc > 0) begin
                    rc--;
                    if (rc == 0) begin bus.resp = 1'b1; bus.rdata = mem_rd(ra); end
                end
                if (bus.req) begin
                    if (aw == 0) begin
                        s_addr = bus.addr; s_we = bus.we; s_wd = bus.wdata;
                    end else if (bus.addr !== s_addr || bus.we !== s_we || bus.wdata !== s_wd) begin
                        unstable++;
                    end
                    if (aw < ack_dly) begin
                        aw++;
                    end else begin
                        aw = 0;
                        bus.ack = 1'b1;
                        ack_cyc = cyc;
                        if (bus.be !== 4'hF) be_bad++;
                        t.we = bus.we; t.addr = bus.addr;
                        if (bus.we) begin
                            t.data = bus.wdata;
                            mem[bus.addr] = bus.wdata;
                        end else begin
                            t.data = mem_rd(bus.addr);
                            ra = bus.addr;
                            if (!no_resp) begin
                                if (resp_dly == 0) begin bus.resp = 1'b1; bus.rdata = t.data; end
                                else rc = resp_dly;
                            end
                        end
                        log_q.push_back(t);
                    end
                end
            end
        end
    end

    int base, d0, e0;

    // Reference: ascending word-by-word copy over a private memory image.
    task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int l);
        logic [31:0] tmp[logic [31:0]];
        logic [31:0] ra, wa, v;
        tmp = exp_mem;
        exp_q.delete();
        for (int i = 0; i < l; i++) begin
            ra = {s[31:2], 2'b00} + 32'(4 * i);
            wa = {d[31:2], 2'b00} + 32'(4 * i);
            v  = tmp.exists(ra) ? tmp[ra] : init_word(ra);
            exp_q.push_back('{1'b0, ra, v});
            tmp[wa] = v;
            exp_q.push_back('{1'b1, wa, v});
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d, input int l);
        build_exp(s, d, l);
        base = log_q.size(); d0 = done_cnt; e0 = err_cnt;
        unstable = 0; be_bad = 0;
        src = s; dst = d; len = LEN_W'(l); start = 1'b1;
        step();
        start = 1'b0; src = $urandom; dst = $urandom; len = LEN_W'($urandom);
    endtask

    task automatic wait_end();
        int n = 0;
        while (!done && !err && n < LIMIT) begin step(); n++; end
        if (n >= LIMIT) chk("wait_bound", 32'd0, 32'd1);
    endtask

    // Compare the first n logged transactions and fold their writes into the model.
    task automatic compare_log(input string tag, input int n);
        chk({tag, "_count"}, 32'(log_q.size() - base), 32'(n));
        for (int i = 0; i < n && base + i < log_q.size(); i++) begin
            chk({tag, "_we"},   32'(log_q[base+i].we), 32'(exp_q[i].we));
            chk({tag, "_addr"}, log_q[base+i].addr, exp_q[i].addr);
            chk({tag, "_data"}, log_q[base+i].data, exp_q[i].data);
            if (exp_q[i].we) exp_mem[exp_q[i].addr] = exp_q[i].data;
        end
        chk({tag, "_stable"}, 32'(unstable), 32'd0);
        chk({tag, "_be"}, 32'(be_bad), 32'd0);
    endtask

    task automatic full_run(input string tag, input logic [31:0] s, input logic [31:0] d, input int l);
        launch(s, d, l);
        wait_end();
        step();
        compare_log(tag, exp_q.size());
        chk({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].we) chk({tag, "_mem"}, mem_rd(exp_q[i].addr), exp_mem[exp_q[i].addr]);
    endtask

    initial begin
        int c;
        arst_n = 1'b0; start = 1'b0; src = 32'd0; dst = 32'd0; len = '0;
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        chk("rst_wdata", bus.wdata, 32'd0);
        #1 arst_n = 1'b1;
        step();

        // Three-word copy with an immediate responder.
        ack_dly = 0; resp_dly = 1;
        launch(32'h100, 32'h200, 3);
        chk("first_req", 32'(bus.req), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        wait_end();
        chk("done_busy_hi", 32'(busy), 32'd1);
        step();
        chk("busy_fall", 32'(busy), 32'd0);
        chk("done_single", 32'(done), 32'd0);
        compare_log("copy3", 6);
        chk("copy3_m0", mem_rd(32'h200), 32'h1111_1111);
        chk("copy3_m1", mem_rd(32'h204), 32'h2222_2222);
        chk("copy3_m2", mem_rd(32'h208), 32'h3333_3333);
        chk("copy3_done", 32'(done_cnt - d0), 32'd1);

        // Zero-length command.
        launch(32'h300, 32'h400, 0);
        c = 1;
        while (!done && c < 20) begin step(); c++; end
        chk("len0_lat", 32'(c), 32'd2);
        step();
        chk("len0_traffic", 32'(log_q.size() - base), 32'd0);

        // Slow responder.
        ack_dly = 5; resp_dly = 7;
        full_run("slow", 32'h400, 32'h500, 3);

        // Missing read response.
        ack_dly = 1; no_resp = 1'b1;
        launch(32'h600, 32'h700, 2);
        wait_end();
        chk("tmo_err", 32'(err_cnt - e0), 32'd1);
        chk("tmo_dist", 32'(err_cyc - ack_cyc), 32'(TMO));
        step();
        chk("tmo_done", 32'(done_cnt - d0), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        chk("tmo_req", 32'(bus.req), 32'd0);
        compare_log("tmo", 1);
        no_resp = 1'b0;

        // Address wrap and unaligned source.
        ack_dly = 0; resp_dly = 1;
        full_run("wrap", 32'hFFFF_FFFC, 32'h10, 2);
        full_run("unal", 32'h103, 32'h300, 1);

        // Reset while the second word's write waits for ack; extra start ignored.
        ack_dly = 3; resp_dly = 2;
        launch(32'h800, 32'hA00, 4);
        step();
        start = 1'b1; src = 32'h900; dst = 32'hB00; len = LEN_W'(1);
        step();
        start = 1'b0;
        c = 0;
        while (!(log_q.size() - base == 3 && bus.req && bus.we) && c < 200) begin step(); c++; end
        chk("rstmid_reach", 32'(c < 200), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("rstmid_req", 32'(bus.req), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        repeat (3) step();
        arst_n = 1'b1;
        repeat (4) step();
        compare_log("rstmid", 3);
        chk("rstmid_done", 32'(done_cnt - d0), 32'd0);
        chk("rstmid_err", 32'(err_cnt - e0), 32'd0);
        full_run("after_rst", 32'h800, 32'hC00, 2);

        // Randomized copies, overlapping ranges allowed.
        for (int k = 0; k < 10; k++) begin
            ack_dly  = $urandom_range(0, 3);
            resp_dly = $urandom_range(0, 4);
            full_run("rand", 32'h1000 + 32'($urandom_range(0, 63)),
                     32'h1000 + 32'($urandom_range(0, 63)), $urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
